// File: rtl/spram_arbiter.sv
// spram_arbiter: shares one synchronous single-port RAM between a CPU port
// (read/write) and a video port (read-only). Each access walks a fixed
// IDLE -> ISSUE -> WAIT -> DONE sequence. The completion ack is high during
// DONE, three cycles after the request was first seen in IDLE.
module spram_arbiter #(
    parameter int unsigned VID_PRIORITY = 0
) (
    input  logic        ram_clk,
    input  logic        ram_rst_n,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,

    input  logic        vid_req,
    input  logic [13:0] vid_addr,
    output logic        vid_ack,
    output logic [15:0] vid_rdata,

    output logic [13:0] ram_addr,
    output logic [15:0] ram_data_in,
    output logic        ram_we,
    input  logic [15:0] ram_data_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic P_VID_WINS = (VID_PRIORITY != 0);

    state_t r_state;
    state_t w_next_state;

    // r_last_vid is the last grant; it also names the port owning the
    // access in flight, because it only changes on IDLE->ISSUE.
    logic   r_last_vid;
    logic   r_acc_we;
    logic   w_any_req;
    logic   w_grant_vid;

    // Arbitration: a lone requester wins; on a tie, video wins when
    // prioritised, otherwise the port not served last time wins.
    always_comb begin
        w_any_req   = cpu_req | vid_req;
        w_grant_vid = vid_req & (~cpu_req | P_VID_WINS | ~r_last_vid);
    end

    // State register.
    always_ff @(posedge ram_clk or negedge ram_rst_n) begin
        if (!ram_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: one step per clock, leaving IDLE only on a request.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT:  w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: RAM command registers, grant history, read capture and acks.
    always_ff @(posedge ram_clk or negedge ram_rst_n) begin
        if (!ram_rst_n) begin
            r_last_vid  <= 1'b0;
            r_acc_we    <= 1'b0;
            ram_addr    <= '0;
            ram_data_in <= '0;
            ram_we      <= 1'b0;
            cpu_ack     <= 1'b0;
            vid_ack     <= 1'b0;
            cpu_rdata   <= '0;
            vid_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_last_vid <= w_grant_vid;
                        if (w_grant_vid) begin
                            ram_addr <= vid_addr;
                            ram_we   <= 1'b0;
                            r_acc_we <= 1'b0;
                        end else begin
                            ram_addr    <= cpu_addr;
                            ram_data_in <= cpu_wdata;
                            ram_we      <= cpu_we;
                            r_acc_we    <= cpu_we;
                        end
                    end
                end
                S_ISSUE: begin
                    ram_we <= 1'b0;
                end
                S_WAIT: begin
                    if (r_last_vid) begin
                        vid_rdata <= ram_data_out;
                        vid_ack   <= 1'b1;
                    end else begin
                        if (!r_acc_we) begin
                            cpu_rdata <= ram_data_out;
                        end
                        cpu_ack <= 1'b1;
                    end
                end
                S_DONE: begin
                    cpu_ack <= 1'b0;
                    vid_ack <= 1'b0;
                end
                default: begin
                    ram_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter: two instances (round-robin and video
// priority), each with its own synchronous RAM model. Stimulus pushes the
// expected ack into a queue; a negedge monitor pops and compares on each ack.
module tb_spram_arbiter;

    typedef struct {
        int unsigned dut;
        bit          vid;
        logic [15:0] cpu_rd;
        logic [15:0] vid_rd;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;

    logic        cpu_req   [2];
    logic        cpu_we    [2];
    logic [13:0] cpu_addr  [2];
    logic [15:0] cpu_wdata [2];
    logic        cpu_ack   [2];
    logic [15:0] cpu_rdata [2];
    logic        vid_req   [2];
    logic [13:0] vid_addr  [2];
    logic        vid_ack   [2];
    logic [15:0] vid_rdata [2];
    logic [13:0] ram_addr  [2];
    logic [15:0] ram_din   [2];
    logic        ram_we    [2];
    logic [15:0] ram_dout  [2];

    logic [15:0] mem [2][16384];
    logic [15:0] last_din [2];

    exp_t        q[$];
    exp_t        e;
    int unsigned we_len [2];
    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM models: address sampled on the edge, data out next cycle.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ram_we[d]) mem[d][ram_addr[d]] <= ram_din[d];
            ram_dout[d] <= mem[d][ram_addr[d]];
        end
    end

    spram_arbiter #(.VID_PRIORITY(0)) u_rr (
        .ram_clk(clk), .ram_rst_n(rst_n),
        .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]),
        .cpu_wdata(cpu_wdata[0]), .cpu_ack(cpu_ack[0]), .cpu_rdata(cpu_rdata[0]),
        .vid_req(vid_req[0]), .vid_addr(vid_addr[0]), .vid_ack(vid_ack[0]),
        .vid_rdata(vid_rdata[0]), .ram_addr(ram_addr[0]), .ram_data_in(ram_din[0]),
        .ram_we(ram_we[0]), .ram_data_out(ram_dout[0])
    );

    spram_arbiter #(.VID_PRIORITY(1)) u_vp (
        .ram_clk(clk), .ram_rst_n(rst_n),
        .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]),
        .cpu_wdata(cpu_wdata[1]), .cpu_ack(cpu_ack[1]), .cpu_rdata(cpu_rdata[1]),
        .vid_req(vid_req[1]), .vid_addr(vid_addr[1]), .vid_ack(vid_ack[1]),
        .vid_rdata(vid_rdata[1]), .ram_addr(ram_addr[1]), .ram_data_in(ram_din[1]),
        .ram_we(ram_we[1]), .ram_data_out(ram_dout[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Monitor: ack exclusivity, scoreboard compare on every ack, ram_we width.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (cpu_ack[d] || vid_ack[d]) begin
                chk("ack_exclusive", 32'(cpu_ack[d] & vid_ack[d]), 32'd0);
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL spurious_ack dut%0d @cyc %0d: got cpu_ack=%0b vid_ack=%0b expected none",
                             d, cyc, cpu_ack[d], vid_ack[d]);
                end else begin
                    e = q.pop_front();
                    chk("ack_dut", 32'(d), 32'(e.dut));
                    chk("ack_port_vid", 32'(vid_ack[d]), 32'(e.vid));
                    chk("cpu_rdata", 32'(cpu_rdata[d]), 32'(e.cpu_rd));
                    chk("vid_rdata", 32'(vid_rdata[d]), 32'(e.vid_rd));
                    chk("ack_cycle", cyc, e.cyc);
                end
            end
            if (!rst_n) begin
                we_len[d] = 0;
            end else if (ram_we[d] === 1'b1) begin
                we_len[d]++;
            end else if (we_len[d] != 0) begin
                chk("we_pulse_len", we_len[d], 32'd1);
                we_len[d] = 0;
            end
        end
    end

    task automatic check_reset_outputs(input int d);
        chk("rst_ram_addr", 32'(ram_addr[d]), 32'd0);
        chk("rst_ram_din", 32'(ram_din[d]), 32'd0);
        chk("rst_ram_we", 32'(ram_we[d]), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack[d]), 32'd0);
        chk("rst_vid_ack", 32'(vid_ack[d]), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata[d]), 32'd0);
        chk("rst_vid_rdata", 32'(vid_rdata[d]), 32'd0);
    endtask

    // Reset mid-cycle, check outputs cleared at once, release just after an edge.
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs(0);
        check_reset_outputs(1);
        last_din[0] = '0;
        last_din[1] = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_ack_drop(input int d, input bit vid);
        bit got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (vid ? vid_ack[d] : cpu_ack[d]) got = 1'b1;
        end
        chk("ack_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        if (vid) vid_req[d] = 1'b0;
        else     cpu_req[d] = 1'b0;
    endtask

    // Single access from an IDLE cycle; also checks the RAM command in ISSUE.
    task automatic access(input int d, input bit vid, input bit we, input logic [13:0] addr,
                          input logic [15:0] wd, input logic [15:0] ecpu, input logic [15:0] evid);
        if (vid) begin
            vid_req[d] = 1'b1; vid_addr[d] = addr;
        end else begin
            cpu_req[d] = 1'b1; cpu_we[d] = we; cpu_addr[d] = addr; cpu_wdata[d] = wd;
        end
        q.push_back('{dut: d, vid: vid, cpu_rd: ecpu, vid_rd: evid, cyc: cyc + 3});
        @(posedge clk); #1;
        if (!vid) last_din[d] = wd;
        chk("issue_addr", 32'(ram_addr[d]), 32'(addr));
        chk("issue_we", 32'(ram_we[d]), 32'(vid ? 1'b0 : we));
        chk("issue_din", 32'(ram_din[d]), 32'(last_din[d]));
        wait_ack_drop(d, vid);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish expected finish by 100000");
        $fatal(1);
    end

    initial begin : stim
        int unsigned c;
        bit got;
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            cpu_req[d] = 1'b0; cpu_we[d] = 1'b0; cpu_addr[d] = '0; cpu_wdata[d] = '0;
            vid_req[d] = 1'b0; vid_addr[d] = '0; last_din[d] = '0; we_len[d] = 0;
        end
        apply_reset();
        @(posedge clk); #1;

        // Write then read back; write at top address; video read of top address.
        access(0, 1'b0, 1'b1, 14'h0123, 16'hBEEF, 16'h0000, 16'h0000);
        access(0, 1'b0, 1'b0, 14'h0123, 16'h0000, 16'hBEEF, 16'h0000);
        access(0, 1'b0, 1'b1, 14'h3FFF, 16'h5A5A, 16'hBEEF, 16'h0000);
        access(0, 1'b1, 1'b0, 14'h3FFF, 16'h0000, 16'hBEEF, 16'h5A5A);

        // Round-robin ties after reset: video, CPU, video, CPU.
        apply_reset();
        c = cyc;
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 14'h0123; cpu_wdata[0] = 16'h0000;
        vid_req[0] = 1'b1; vid_addr[0] = 14'h3FFF;
        q.push_back('{dut: 0, vid: 1'b1, cpu_rd: 16'h0000, vid_rd: 16'h5A5A, cyc: c + 3});
        q.push_back('{dut: 0, vid: 1'b0, cpu_rd: 16'hBEEF, vid_rd: 16'h5A5A, cyc: c + 7});
        q.push_back('{dut: 0, vid: 1'b1, cpu_rd: 16'hBEEF, vid_rd: 16'h5A5A, cyc: c + 11});
        q.push_back('{dut: 0, vid: 1'b0, cpu_rd: 16'hBEEF, vid_rd: 16'h5A5A, cyc: c + 15});
        repeat (16) @(posedge clk);
        #1;
        cpu_req[0] = 1'b0; vid_req[0] = 1'b0;
        chk("tie_rr_drained", q.size(), 32'd0);

        // Reset during WAIT of a CPU read: no ack, outputs cleared, request restarts.
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 14'h0123; cpu_wdata[0] = 16'h0000;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_din[0] = '0;
        q.push_back('{dut: 0, vid: 1'b0, cpu_rd: 16'hBEEF, vid_rd: 16'h0000, cyc: cyc + 3});
        wait_ack_drop(0, 1'b0);

        // Video request raised during DONE waits for the next IDLE.
        c = cyc;
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 14'h0200; cpu_wdata[0] = 16'h1234;
        last_din[0] = 16'h1234;
        q.push_back('{dut: 0, vid: 1'b0, cpu_rd: 16'hBEEF, vid_rd: 16'h0000, cyc: c + 3});
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (cpu_ack[0]) got = 1'b1;
        end
        chk("done_ack_seen", 32'(got), 32'd1);
        vid_req[0] = 1'b1; vid_addr[0] = 14'h0123;
        q.push_back('{dut: 0, vid: 1'b1, cpu_rd: 16'hBEEF, vid_rd: 16'hBEEF, cyc: cyc + 4});
        @(posedge clk); #1;
        cpu_req[0] = 1'b0;
        wait_ack_drop(0, 1'b1);
        access(0, 1'b0, 1'b0, 14'h0200, 16'h0000, 16'h1234, 16'hBEEF);

        // Video priority: CPU starved while video is held, served once it drops.
        access(1, 1'b0, 1'b1, 14'h0456, 16'hA5A5, 16'h0000, 16'h0000);
        access(1, 1'b0, 1'b1, 14'h0789, 16'h1111, 16'h0000, 16'h0000);
        c = cyc;
        cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 14'h0789; cpu_wdata[1] = 16'h0000;
        vid_req[1] = 1'b1; vid_addr[1] = 14'h0456;
        for (int k = 0; k < 4; k++)
            q.push_back('{dut: 1, vid: 1'b1, cpu_rd: 16'h0000, vid_rd: 16'hA5A5, cyc: c + 3 + 4 * k});
        repeat (16) @(posedge clk);
        #1;
        vid_req[1] = 1'b0;
        q.push_back('{dut: 1, vid: 1'b0, cpu_rd: 16'h1111, vid_rd: 16'hA5A5, cyc: c + 19});
        wait_ack_drop(1, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
